// File: rtl/sccb_cfg_arbiter.sv
// Round-robin arbiter sharing the camera SCCB register-write master among
// N_REQ requesters. One write is owned per grant; gated requesters wait for
// start-of-frame, NACKs are retried after a backoff, and a stuck master is
// aborted on timeout. The outcome is returned to the granted requester.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no owner; waiting for any valid request
// S_ARB      | pick winner from rr pointer, strobe ready, latch addr/data
// S_WAIT_SOF | gated winner waits for an i_sof seen after the ARB cycle
// S_ISSUE    | one-cycle o_m_start to the master, timeout counter cleared
// S_WAIT_DONE| waiting for i_m_done or timeout
// S_BACKOFF  | idle gap after a NACK before re-issuing
// S_RESP     | one-cycle completion strobe to the owner, then idle
module sccb_cfg_arbiter #(
    parameter int                N_REQ         = 3,
    parameter logic [N_REQ-1:0]  SOF_GATE_MASK = 3'b110,
    parameter int                MAX_RETRY     = 3,
    parameter int                TIMEOUT_CYC   = 2000000,
    parameter int                BACKOFF_CYC   = 100000
) (
    input  logic                 clk_100MHz,
    input  logic                 btn_rstn,
    input  logic                 i_sof,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_addr,
    input  logic [8*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [N_REQ-1:0]     o_rsp_err,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_m_start,
    output logic [7:0]           o_m_addr,
    output logic [7:0]           o_m_data,
    input  logic                 i_m_done,
    input  logic                 i_m_nack
);

    localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_SOF,
        S_ISSUE,
        S_WAIT_DONE,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               err_q, err_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_inc;
    logic [7:0]         m_addr_q, m_data_q;
    logic               latch_en;

    logic               sel_found;
    logic [PW-1:0]      sel_idx;
    logic [N_REQ-1:0]   sel_oh;
    logic [PW-1:0]      rr_nxt;
    logic [7:0]         sel_addr, sel_data;
    int                 scan;
    logic [PW-1:0]      scan_idx;

    assign cnt_inc = cnt_q + CW'(1);

    // Round-robin search: first valid requester at or above rr_q, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_oh    = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan     = (int'(rr_q) + k) % N_REQ;
            scan_idx = scan[PW-1:0];
            if (!sel_found && i_req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
        if (sel_found) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    assign rr_nxt   = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + PW'(1);
    assign sel_addr = i_req_addr[{sel_idx, 3'b000} +: 8];
    assign sel_data = i_req_data[{sel_idx, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk_100MHz or negedge btn_rstn) begin
        if (!btn_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus next values for the grant/retry/counter datapath.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        err_d    = err_q;
        retry_d  = retry_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|i_req_valid) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (sel_found) begin
                    grant_d  = sel_oh;
                    rr_d     = rr_nxt;
                    latch_en = 1'b1;
                    err_d    = 1'b0;
                    state_d  = SOF_GATE_MASK[sel_idx] ? S_WAIT_SOF : S_ISSUE;
                end else begin
                    // request withdrawn before arbitration: nobody is granted
                    state_d = S_IDLE;
                end
            end
            S_WAIT_SOF: begin
                if (i_sof) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (i_m_done) begin
                    // done takes priority over a timeout in the same cycle
                    if (!i_m_nack) begin
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        cnt_d   = '0;
                        state_d = S_BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (cnt_inc == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_BACKOFF: begin
                if (cnt_q == CW'(BACKOFF_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                retry_d = '0;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers: rr pointer, owner, status, counters, latched write.
    always_ff @(posedge clk_100MHz or negedge btn_rstn) begin
        if (!btn_rstn) begin
            rr_q     <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
            retry_q  <= '0;
            cnt_q    <= '0;
            m_addr_q <= 8'h00;
            m_data_q <= 8'h00;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                m_addr_q <= sel_addr;
                m_data_q <= sel_data;
            end
        end
    end

    assign o_req_ready = (state_q == S_ARB) ? sel_oh : '0;
    assign o_grant     = grant_q | o_req_ready;
    assign o_rsp_valid = (state_q == S_RESP) ? grant_q : '0;
    assign o_rsp_err   = ((state_q == S_RESP) && err_q) ? grant_q : '0;
    assign o_busy      = (state_q != S_IDLE);
    assign o_m_start   = (state_q == S_ISSUE);
    assign o_m_addr    = m_addr_q;
    assign o_m_data    = m_data_q;

endmodule

// File: tb/tb_sccb_cfg_arbiter.sv
// Directed bench for sccb_cfg_arbiter with shortened timeout/backoff.
module tb_sccb_cfg_arbiter;

    localparam int N  = 3;
    localparam int T  = 100;
    localparam int B  = 30;
    localparam int MR = 3;

    logic        clk_100MHz;
    logic        btn_rstn;
    logic        sof_gen, sof_man;
    logic        i_sof;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_addr, req_data;
    logic [N-1:0]   o_req_ready, o_rsp_valid, o_rsp_err, o_grant;
    logic        o_busy, o_m_start;
    logic [7:0]  o_m_addr, o_m_data;
    logic        done_auto, nack_auto, done_man, nack_man;
    logic        i_m_done, i_m_nack;

    assign i_sof    = sof_gen | sof_man;
    assign i_m_done = done_auto | done_man;
    assign i_m_nack = done_auto ? nack_auto : nack_man;

    sccb_cfg_arbiter #(
        .N_REQ(N), .SOF_GATE_MASK(3'b110), .MAX_RETRY(MR),
        .TIMEOUT_CYC(T), .BACKOFF_CYC(B)
    ) dut (
        .clk_100MHz(clk_100MHz), .btn_rstn(btn_rstn), .i_sof(i_sof),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err),
        .o_grant(o_grant), .o_busy(o_busy), .o_m_start(o_m_start),
        .o_m_addr(o_m_addr), .o_m_data(o_m_data),
        .i_m_done(i_m_done), .i_m_nack(i_m_nack)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    int cyc;
    int total, bad;
    int start_q[$];
    logic [15:0] start_ad_q[$];
    int rdy_cyc_q[$];
    logic [N-1:0] rdy_vec_q[$];
    int rsp_count, rsp_cyc;
    logic [N-1:0] rsp_vec, rsp_err;
    bit auto_en, armed, sof_en;
    int ack_delay, dly, nacks_left;
    int t, s, u;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rdy_cyc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, rdy_cyc_q.size(), n);
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rsp_count < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, rsp_count, n);
    endtask

    task automatic clr_logs();
        start_q.delete();
        start_ad_q.delete();
        rdy_cyc_q.delete();
        rdy_vec_q.delete();
        rsp_count = 0;
        rsp_cyc   = 0;
        rsp_vec   = '0;
        rsp_err   = '0;
    endtask

    task automatic do_reset();
        btn_rstn  = 1'b0;
        req_valid = '0;
        sof_man   = 1'b0;
        done_man  = 1'b0;
        done_auto = 1'b0;
        armed     = 1'b0;
        repeat (3) tick();
        btn_rstn = 1'b1;
        clr_logs();
        tick();
    endtask

    // Present one write from requester r, hold until ready, then withdraw.
    task automatic req_one(input int r, input logic [7:0] a, input logic [7:0] d, output int tv);
        int n0;
        n0 = rdy_cyc_q.size();
        req_addr  = (req_addr & ~(24'hFF << (8 * r))) | (24'(a) << (8 * r));
        req_data  = (req_data & ~(24'hFF << (8 * r))) | (24'(d) << (8 * r));
        req_valid = req_valid | (3'b001 << r);
        tv = cyc;
        wait_ready(n0 + 1, 500, "ready_wait");
        tick();
        req_valid = req_valid & ~(3'b001 << r);
    endtask

    function automatic int next_sof(input int r);
        return ((r / 200) + 1) * 200;
    endfunction

    initial begin
        btn_rstn = 1'b0; sof_gen = 1'b0; sof_man = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        done_auto = 1'b0; nack_auto = 1'b0; done_man = 1'b0; nack_man = 1'b0;
        cyc = 0; total = 0; bad = 0;
        auto_en = 1'b1; armed = 1'b0; sof_en = 1'b0;
        ack_delay = 50; dly = 0; nacks_left = 0;
        clr_logs();

        fork
            forever begin
                @(posedge clk_100MHz);
                cyc++;
            end
            // Monitor and master model, sampled on the falling edge.
            forever begin
                @(negedge clk_100MHz);
                if (o_m_start) begin
                    start_q.push_back(cyc);
                    start_ad_q.push_back({o_m_addr, o_m_data});
                end
                if (|o_req_ready) begin
                    rdy_cyc_q.push_back(cyc);
                    rdy_vec_q.push_back(o_req_ready);
                end
                if (|o_rsp_valid) begin
                    rsp_count++;
                    rsp_cyc = cyc;
                    rsp_vec = o_rsp_valid;
                    rsp_err = o_rsp_err;
                end
                done_auto = 1'b0;
                nack_auto = 1'b0;
                if (armed) begin
                    if (dly <= 1) begin
                        done_auto = 1'b1;
                        if (nacks_left > 0) begin
                            nack_auto = 1'b1;
                            nacks_left--;
                        end
                        armed = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                if (o_m_start && auto_en) begin
                    armed = 1'b1;
                    dly   = ack_delay;
                end
            end
            forever begin
                @(posedge clk_100MHz);
                #1;
                sof_gen = sof_en && (cyc % 200 == 0);
            end
        join_none

        // Reset values
        #12;
        req_valid = 3'b111;
        check("rst_ctrl_outs", {o_busy, o_grant, o_req_ready, o_rsp_valid, o_rsp_err, o_m_start}, 0);
        check("rst_addr_data", {o_m_addr, o_m_data}, 0);
        req_valid = '0;
        tick(); tick();
        btn_rstn = 1'b1;
        tick();

        // Single ungated write from requester 0
        req_one(0, 8'h12, 8'h80, t);
        check("t1_ready_cyc", rdy_cyc_q[0], t + 1);
        check("t1_ready_vec", rdy_vec_q[0], 3'b001);
        check("t1_start_cyc", start_q[0], t + 2);
        check("t1_addr_data", start_ad_q[0], 16'h1280);
        check("t1_grant_held", {o_busy, o_grant}, 4'b1001);
        wait_rsp(1, 200, "t1_rsp_wait");
        check("t1_rsp_cyc", rsp_cyc, t + 53);
        check("t1_rsp_vec", rsp_vec, 3'b001);
        check("t1_rsp_err", rsp_err, 3'b000);
        check("t1_idle", {o_busy, o_grant}, 4'b0000);

        // Stray done while idle
        nack_man = 1'b0; done_man = 1'b1;
        tick();
        done_man = 1'b0;
        tick();
        check("stray_idle_busy", o_busy, 1'b0);
        check("stray_idle_rsp", rsp_count, 1);
        check("stray_idle_start", start_q.size(), 1);

        // Round robin with all three valid and SOF every 200 cycles
        do_reset();
        ack_delay = 10; sof_en = 1'b1;
        req_addr = {8'h33, 8'h22, 8'h11};
        req_data = {8'hC3, 8'hB2, 8'hA1};
        req_valid = 3'b111;
        wait_ready(4, 1500, "rr_ready_wait");
        tick();
        req_valid = '0;
        wait_rsp(4, 300, "rr_rsp_wait");
        sof_en = 1'b0;
        check("rr_g0", rdy_vec_q[0], 3'b001);
        check("rr_g1", rdy_vec_q[1], 3'b010);
        check("rr_g2", rdy_vec_q[2], 3'b100);
        check("rr_g3", rdy_vec_q[3], 3'b001);
        check("rr_arb_gap", rdy_cyc_q[1], rdy_cyc_q[0] + 14);
        check("rr_s0", start_q[0], rdy_cyc_q[0] + 1);
        check("rr_s1_sof", start_q[1], next_sof(rdy_cyc_q[1]) + 1);
        check("rr_s2_sof", start_q[2], next_sof(rdy_cyc_q[2]) + 1);
        check("rr_s3", start_q[3], rdy_cyc_q[3] + 1);
        check("rr_ad1", start_ad_q[1], 16'h22B2);
        check("rr_ad2", start_ad_q[2], 16'h33C3);

        // SOF during the ARB cycle must not release a gated write
        do_reset();
        req_addr = (req_addr & ~24'h00FF00) | 24'h004400;
        req_data = (req_data & ~24'h00FF00) | 24'h005500;
        req_valid = 3'b010;
        t = cyc;
        tick();
        sof_man = 1'b1;
        tick();
        sof_man = 1'b0;
        req_valid = '0;
        check("sof_arb_ready", rdy_cyc_q[0], t + 1);
        repeat (5) tick();
        check("sof_arb_nostart", start_q.size(), 0);
        check("sof_arb_busy", o_busy, 1'b1);
        sof_man = 1'b1;
        tick();
        sof_man = 1'b0;
        wait_rsp(1, 100, "sof_rsp_wait");
        check("sof_start_cyc", start_q[0], t + 8);
        check("sof_addr_data", start_ad_q[0], 16'h4455);
        check("sof_rsp_cyc", rsp_cyc, t + 19);

        // NACK on every attempt: 1 + MAX_RETRY starts, then error
        do_reset();
        ack_delay = 5; nacks_left = 100;
        req_one(0, 8'h0A, 8'h0B, t);
        wait_rsp(1, 400, "nack_rsp_wait");
        check("nack_starts", start_q.size(), 4);
        check("nack_s0", start_q[0], t + 2);
        for (int i = 1; i < 4; i++) begin
            check("nack_spacing", start_q[i] - start_q[i-1], 36);
        end
        check("nack_rsp_cyc", rsp_cyc, start_q[3] + 6);
        check("nack_rsp_vec", rsp_vec, 3'b001);
        check("nack_rsp_err", rsp_err, 3'b001);

        // NACK then ACK, with a stray done during BACKOFF
        clr_logs();
        nacks_left = 1;
        req_one(0, 8'h0C, 8'h0D, t);
        repeat (14) tick();
        nack_man = 1'b0; done_man = 1'b1;
        tick();
        done_man = 1'b0;
        wait_rsp(1, 200, "retry_rsp_wait");
        check("retry_starts", start_q.size(), 2);
        check("retry_spacing", start_q[1] - start_q[0], 36);
        check("retry_rsp_cyc", rsp_cyc, start_q[1] + 6);
        check("retry_rsp_err", rsp_err, 3'b000);

        // Master never answers: timeout error T cycles after start
        do_reset();
        auto_en = 1'b0; nacks_left = 0;
        req_one(0, 8'h21, 8'h43, t);
        s = t + 2;
        check("tmo_busy", o_busy, 1'b1);
        wait_rsp(1, 300, "tmo_rsp_wait");
        check("tmo_starts", start_q.size(), 1);
        check("tmo_rsp_cyc", rsp_cyc, s + T);
        check("tmo_rsp_err", rsp_err, 3'b001);
        check("tmo_idle", o_busy, 1'b0);

        // Done on the timeout cycle wins; one cycle later it is too late
        clr_logs();
        auto_en = 1'b1; ack_delay = T - 1;
        req_one(0, 8'h31, 8'h32, t);
        wait_rsp(1, 300, "edge_rsp_wait");
        check("edge_rsp_cyc", rsp_cyc, t + 2 + T);
        check("edge_rsp_err", rsp_err, 3'b000);
        tick();
        clr_logs();
        ack_delay = T;
        req_one(0, 8'h31, 8'h32, t);
        wait_rsp(1, 300, "late_rsp_wait");
        check("late_rsp_cyc", rsp_cyc, t + 2 + T);
        check("late_rsp_err", rsp_err, 3'b001);
        tick(); tick();
        check("late_idle", o_busy, 1'b0);

        // Reset in WAIT_DONE: outputs clear at once, rr restarts at 0
        do_reset();
        auto_en = 1'b0;
        req_addr = 24'h550066;
        req_data = 24'h770088;
        req_valid = 3'b101;
        wait_ready(1, 20, "rst_ready_wait");
        check("rst_first_grant", rdy_vec_q[0], 3'b001);
        repeat (8) tick();
        check("rst_pre_busy", o_busy, 1'b1);
        btn_rstn = 1'b0;
        #1;
        check("rst_mid_outs", {o_busy, o_grant, o_req_ready, o_rsp_valid, o_rsp_err, o_m_start}, 0);
        check("rst_mid_ad", {o_m_addr, o_m_data}, 0);
        repeat (3) tick();
        btn_rstn = 1'b1;
        u = cyc;
        check("rst_no_rsp", rsp_count, 0);
        wait_ready(2, 20, "rst_rearb_wait");
        check("rst_rearb_vec", rdy_vec_q[1], 3'b001);
        check("rst_rearb_cyc", rdy_cyc_q[1], u + 1);
        req_valid = '0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
